sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Simulation-side run sequencer for the SoC top under test.
- Replaces hard-tied panel buttons with a scripted sequence: clear PU, load the program from the input device, arrange the start address, start the PU, then wait for the machine to halt.
- Reports done or timeout to the C++ harness.
- Sits beside the input and output device models, inside the simulation top.

Parameters:
- STOP_CYCLES, 255: consecutive quiet cycles that count as "machine stopped" (1..65535).
- TIMEOUT_CYCLES, 1000000: maximum cycles spent in either wait phase before error (1..2^32-1).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- run_req  in  1  level; sampled only in IDLE/DONE/ERR; starts a sequence.
- entry_addr  in  12  program start address, latched when run_req is accepted.
- pu_state  in  3  PU state from the SoC; 3'o0 = halted.
- input_active  in  1  input device active indicator from the SoC panel.
- output_active  in  1  output device active indicator from the SoC panel.
- btn_clear_pu  out  1  one-cycle clear-PU pulse.
- btn_start_input  out  1  one-cycle start-input pulse.
- pnl_do_arr_strt  out  1  one-cycle arrange-start-address strobe.
- pnl_arr_strt_value  out  12  latched entry_addr.
- btn_start_pulse  out  1  one-cycle PU start pulse.
- busy  out  1  high from CLEAR through WAIT_RUN.
- done  out  1  high in DONE.
- timeout  out  1  high in ERR.
- phase  out  3  state encoding, for waveform and debug.

Behaviour:
- Reset: when resetn=0 at a posedge, state=IDLE and all outputs=0 (pnl_arr_strt_value=0). Counters and arm flag clear. Reset mid-sequence aborts immediately; no pulse is emitted in the following cycle.
- States and phase codes: IDLE=0, CLEAR=1, LOAD=2, WAIT_LOAD=3, SET_STRT=4, RUN=5, WAIT_RUN=6, DONE/ERR=7. done and timeout distinguish DONE from ERR.
- All outputs are registered and change only at posedge.
- IDLE/DONE/ERR, run_req=1: latch entry_addr, clear done/timeout, go to CLEAR. done and timeout stay held until that acceptance.
- CLEAR: btn_clear_pu=1 for exactly this cycle, then LOAD.
- LOAD: btn_start_input=1 for exactly this cycle, then WAIT_LOAD. Clear quiet counter, timeout counter and arm flag.
- WAIT_LOAD:
  - Arm flag sets on the first cycle input_active=1.
  - Once armed, the quiet counter increments on each cycle with pu_state==0 && !input_active && !output_active. Any other cycle resets it to 0. It saturates at STOP_CYCLES.
  - Quiet counter reaching STOP_CYCLES goes to SET_STRT.
- SET_STRT: pnl_do_arr_strt=1 for one cycle, with pnl_arr_strt_value stable from the CLEAR cycle onward. Then RUN.
- RUN: btn_start_pulse=1 for one cycle, then WAIT_RUN. Counters and arm flag clear.
- WAIT_RUN: same quiet rule as WAIT_LOAD, but the arm flag sets on the first cycle pu_state!=0. On stop, go to DONE (done=1, busy=0).
- Timeout counter:
  - Increments every cycle in WAIT_LOAD and WAIT_RUN.
  - When it equals TIMEOUT_CYCLES-1 and the stop condition is not met in that same cycle, go to ERR (timeout=1, busy=0).
  - If the stop condition and timeout coincide, stop wins.
- Latency: run_req accepted at cycle 0 gives btn_clear_pu at cycle 1, btn_start_input at 2, and WAIT_LOAD from 3. The stop condition met at cycle n gives pnl_do_arr_strt at n+1 and btn_start_pulse at n+2.
- run_req held high after DONE/ERR restarts immediately; the harness must drop it to run only once.
- run_req is ignored while busy.
- Counter widths: quiet counter 16 bits, timeout counter 32 bits.

Optional Feature:
- Macro SIM_RUN_CTRL_CYCLE_COUNT_EN.
- Defined: adds output port run_cycles (32 bits).
  - Clears on entering RUN.
  - Increments each WAIT_RUN cycle.
  - Freezes at DONE/ERR and holds until the next RUN.
  - Reset value 0. Wraps modulo 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Nominal run: STOP_CYCLES=4, run_req pulse, entry_addr=12'h040.
  - Model: input_active high for 10 cycles then low, pu_state=0; later pu_state=3'o2 for 20 cycles then 0.
  - Expect pulse order clear, start_input, do_arr_strt with value 12'h040, start_pulse.
  - Expect done=1 exactly 4 quiet cycles after pu_state returns to 0, busy=0.
- Load never starts: input_active stuck 0, TIMEOUT_CYCLES=50 -> timeout=1 exactly 50 cycles after entering WAIT_LOAD; no pnl_do_arr_strt pulse.
- Quiet interrupted: in WAIT_RUN, pu_state=0 for 3 cycles, output_active=1 for 1 cycle, then quiet (STOP_CYCLES=4) -> counter resets; done asserts 4 cycles after output_active falls.
- Reset mid-op: resetn=0 during WAIT_RUN -> next cycle phase=0, all outputs 0; run_req after release starts a fresh sequence from CLEAR.
- Simultaneous stop and timeout: STOP_CYCLES=4, TIMEOUT_CYCLES=10, 4th quiet cycle on the 10th WAIT_RUN cycle -> done=1, timeout=0.
- With SIM_RUN_CTRL_CYCLE_COUNT_EN: nominal run with 20 busy + 4 quiet WAIT_RUN cycles -> run_cycles=24 at DONE, and still 24 ten cycles later.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Scripted run sequencer: clear PU, load program, set start address, start PU, wait for halt.
// Optional run_cycles counter/port is enabled by defining SIM_RUN_CTRL_CYCLE_COUNT_EN.
module sim_run_ctrl #(
    parameter int unsigned STOP_CYCLES    = 255,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run_req,
    input  logic [11:0] entry_addr,
    input  logic [2:0]  pu_state,
    input  logic        input_active,
    input  logic        output_active,
    output logic        btn_clear_pu,
    output logic        btn_start_input,
    output logic        pnl_do_arr_strt,
    output logic [11:0] pnl_arr_strt_value,
    output logic        btn_start_pulse,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [2:0]  phase
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
    ,
    output logic [31:0] run_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_LOAD      = 3'd2,
        S_WAIT_LOAD = 3'd3,
        S_SET_STRT  = 3'd4,
        S_RUN       = 3'd5,
        S_WAIT_RUN  = 3'd6,
        S_END       = 3'd7   // DONE or ERR, told apart by done/timeout
    } state_t;

    localparam logic [15:0] STOP_Q   = STOP_CYCLES[15:0];
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] quiet_cnt;
    logic [31:0] tmo_cnt;
    logic        arm;

    logic        quiet;
    logic [15:0] quiet_nxt;
    logic        stop_hit;
    logic        tmo_hit;

    assign phase = state;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        quiet     = (pu_state == 3'o0) && !input_active && !output_active;
        quiet_nxt = '0;
        if (arm && quiet) begin
            quiet_nxt = (quiet_cnt == STOP_Q) ? quiet_cnt : quiet_cnt + 16'd1;
        end
        stop_hit = (quiet_nxt == STOP_Q);
        tmo_hit  = (tmo_cnt == TMO_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state              <= S_IDLE;
            btn_clear_pu       <= 1'b0;
            btn_start_input    <= 1'b0;
            pnl_do_arr_strt    <= 1'b0;
            pnl_arr_strt_value <= '0;
            btn_start_pulse    <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timeout            <= 1'b0;
            quiet_cnt          <= '0;
            tmo_cnt            <= '0;
            arm                <= 1'b0;
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
            run_cycles         <= '0;
`endif
        end else begin
            btn_clear_pu    <= 1'b0;
            btn_start_input <= 1'b0;
            pnl_do_arr_strt <= 1'b0;
            btn_start_pulse <= 1'b0;
            case (state)
                S_IDLE, S_END: begin
                    if (run_req) begin
                        pnl_arr_strt_value <= entry_addr;
                        done               <= 1'b0;
                        timeout            <= 1'b0;
                        busy               <= 1'b1;
                        btn_clear_pu       <= 1'b1;
                        state              <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    btn_start_input <= 1'b1;
                    state           <= S_LOAD;
                end
                S_LOAD: begin
                    quiet_cnt <= '0;
                    tmo_cnt   <= '0;
                    arm       <= 1'b0;
                    state     <= S_WAIT_LOAD;
                end
                S_WAIT_LOAD: begin
                    arm       <= arm | input_active;
                    quiet_cnt <= quiet_nxt;
                    tmo_cnt   <= tmo_cnt + 32'd1;
                    // A stop in the last allowed cycle beats the timeout.
                    if (stop_hit) begin
                        pnl_do_arr_strt <= 1'b1;
                        state           <= S_SET_STRT;
                    end else if (tmo_hit) begin
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= S_END;
                    end
                end
                S_SET_STRT: begin
                    btn_start_pulse <= 1'b1;
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
                    run_cycles      <= '0;
`endif
                    state           <= S_RUN;
                end
                S_RUN: begin
                    quiet_cnt <= '0;
                    tmo_cnt   <= '0;
                    arm       <= 1'b0;
                    state     <= S_WAIT_RUN;
                end
                S_WAIT_RUN: begin
                    arm        <= arm | (pu_state != 3'o0);
                    quiet_cnt  <= quiet_nxt;
                    tmo_cnt    <= tmo_cnt + 32'd1;
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
                    run_cycles <= run_cycles + 32'd1;
`endif
                    if (stop_hit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_END;
                    end else if (tmo_hit) begin
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= S_END;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl: scenario table plus an event scoreboard of expected pulses.
// Two instances share stimulus: dut_a (STOP=4, TIMEOUT=50) and dut_b (STOP=4, TIMEOUT=10).
module tb_sim_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        run_req;
    logic [11:0] entry_addr;
    logic [2:0]  pu_state;
    logic        input_active;
    logic        output_active;

    typedef struct packed {
        logic        clear;
        logic        sinp;
        logic        arr;
        logic [11:0] val;
        logic        start;
        logic        busy;
        logic        done;
        logic        timeout;
        logic [2:0]  phase;
    } obs_t;

    logic        a_clear, a_sinp, a_arr, a_start, a_busy, a_done, a_tmo;
    logic [11:0] a_val;
    logic [2:0]  a_phase;
    logic        b_clear, b_sinp, b_arr, b_start, b_busy, b_done, b_tmo;
    logic [11:0] b_val;
    logic [2:0]  b_phase;
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
    logic [31:0] a_rc, b_rc;
`endif
    obs_t oa, ob;
    assign oa = {a_clear, a_sinp, a_arr, a_val, a_start, a_busy, a_done, a_tmo, a_phase};
    assign ob = {b_clear, b_sinp, b_arr, b_val, b_start, b_busy, b_done, b_tmo, b_phase};

    sim_run_ctrl #(.STOP_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_a (
        .clk(clk), .resetn(resetn), .run_req(run_req), .entry_addr(entry_addr),
        .pu_state(pu_state), .input_active(input_active), .output_active(output_active),
        .btn_clear_pu(a_clear), .btn_start_input(a_sinp), .pnl_do_arr_strt(a_arr),
        .pnl_arr_strt_value(a_val), .btn_start_pulse(a_start), .busy(a_busy),
        .done(a_done), .timeout(a_tmo), .phase(a_phase)
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
        , .run_cycles(a_rc)
`endif
    );

    sim_run_ctrl #(.STOP_CYCLES(4), .TIMEOUT_CYCLES(10)) dut_b (
        .clk(clk), .resetn(resetn), .run_req(run_req), .entry_addr(entry_addr),
        .pu_state(pu_state), .input_active(input_active), .output_active(output_active),
        .btn_clear_pu(b_clear), .btn_start_input(b_sinp), .pnl_do_arr_strt(b_arr),
        .pnl_arr_strt_value(b_val), .btn_start_pulse(b_start), .busy(b_busy),
        .done(b_done), .timeout(b_tmo), .phase(b_phase)
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
        , .run_cycles(b_rc)
`endif
    );

    localparam int K_CLEAR = 0;
    localparam int K_SINP  = 1;
    localparam int K_ARR   = 2;
    localparam int K_START = 3;
    localparam int K_DONE  = 4;
    localparam int K_TMO   = 5;

    typedef struct {
        int          kind;
        int          cyc;
        logic [11:0] val;
    } ev_t;

    // l: input_active cycles in WAIT_LOAD (0 = load never starts)
    // b: pu_state busy cycles in WAIT_RUN; g: quiet cycles before a 1-cycle output_active glitch (-1 = none)
    // abort: relative cycle at which resetn is pulled low (0 = none)
    typedef struct {
        logic        sel;
        logic [11:0] addr;
        int          l;
        int          b;
        int          g;
        int          abort;
        logic        exp_done;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    logic sel_b    = 1'b0;
    logic prev_done, prev_tmo;

    function automatic obs_t cur();
        return sel_b ? ob : oa;
    endfunction

`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
    function automatic logic [31:0] cur_rc();
        return sel_b ? b_rc : a_rc;
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [11:0] val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input obs_t o);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected event: kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event kind", 32'(kind), 32'(e.kind));
            check("event cycle", 32'(cyc), 32'(e.cyc));
            if (kind == K_ARR) check("arr value", 32'(o.val), 32'(e.val));
            if (kind == K_CLEAR) check("clear flags", 32'({o.busy, o.done, o.timeout}), 32'd4);
        end
    endtask

    // One clock: sample #1 after the edge and feed any pulse/flag events to the scoreboard.
    task automatic step();
        obs_t o;
        @(posedge clk);
        #1;
        cyc++;
        o = cur();
        if (o.clear) observe(K_CLEAR, o);
        if (o.sinp)  observe(K_SINP, o);
        if (o.arr)   observe(K_ARR, o);
        if (o.start) observe(K_START, o);
        if (o.done && !prev_done)   observe(K_DONE, o);
        if (o.timeout && !prev_tmo) observe(K_TMO, o);
        prev_done = o.done;
        prev_tmo  = o.timeout;
    endtask

    task automatic idle_inputs();
        run_req       = 1'b0;
        entry_addr    = 12'h000;
        pu_state      = 3'o0;
        input_active  = 1'b0;
        output_active = 1'b0;
        resetn        = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        check("reset outputs a", 32'(oa), 32'd0);
        check("reset outputs b", 32'(ob), 32'd0);
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
        check("reset run_cycles", cur_rc(), 32'd0);
`endif
        resetn    = 1'b1;
        prev_done = 1'b0;
        prev_tmo  = 1'b0;
    endtask

    task automatic run_seq(input vec_t v);
        int c0, w, q0, end_rel, lim, tmo, t;
        c0  = cyc;
        w   = v.l + 9;
        tmo = v.sel ? 10 : 50;
        q0  = w + v.b + ((v.g >= 0) ? v.g + 1 : 0);
        if (v.abort > 0)     end_rel = v.abort;
        else if (v.l == 0)   end_rel = 3 + tmo;
        else if (v.exp_done) end_rel = q0 + 4;
        else                 end_rel = w + tmo;
        lim = (v.abort > 0) ? v.abort + 1 : end_rel;

        push(K_CLEAR, c0 + 1, 12'h000);
        push(K_SINP, c0 + 2, 12'h000);
        if (v.l > 0 && v.l + 7 <= end_rel) push(K_ARR, c0 + v.l + 7, v.addr);
        if (v.l > 0 && v.l + 8 <= end_rel) push(K_START, c0 + v.l + 8, 12'h000);
        if (v.abort == 0) push(v.exp_done ? K_DONE : K_TMO, c0 + end_rel, 12'h000);

        while (cyc - c0 < lim) begin
            t = cyc - c0;
            // Extra run_req at t=5 lands in WAIT_LOAD and must be ignored; the address bus changes after acceptance.
            run_req       = (t == 0) || (t == 5);
            entry_addr    = (t == 0) ? v.addr : ~v.addr;
            input_active  = (v.l > 0) && (t >= 3) && (t < 3 + v.l);
            pu_state      = (t >= w && t < w + v.b) ? 3'o2 : 3'o0;
            output_active = (v.g >= 0) && (t == w + v.b + v.g);
            resetn        = !((v.abort > 0) && (t == v.abort));
            step();
        end
        idle_inputs();
        check("events drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        if (v.abort > 0) begin
            check("abort outputs", 32'(cur()), 32'd0);
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
            check("abort run_cycles", cur_rc(), 32'd0);
`endif
            step();
            check("post-abort outputs", 32'(cur()), 32'd0);
        end else begin
            check("final flags", 32'({cur().busy, cur().done, cur().timeout, cur().phase}),
                  32'({1'b0, v.exp_done, !v.exp_done, 3'd7}));
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
            if (v.l > 0) check("run_cycles at end", cur_rc(), 32'(end_rel - w));
`endif
            repeat (10) step();
            check("flags held", 32'({cur().busy, cur().done, cur().timeout, cur().phase}),
                  32'({1'b0, v.exp_done, !v.exp_done, 3'd7}));
`ifdef SIM_RUN_CTRL_CYCLE_COUNT_EN
            if (v.l > 0) check("run_cycles held", cur_rc(), 32'(end_rel - w));
`endif
        end
    endtask

    initial begin
        //           sel   addr     l   b   g  abort done
        vecs[0] = '{1'b0, 12'h040, 10, 20, -1, 0,  1'b1};  // nominal
        vecs[1] = '{1'b0, 12'h7FF, 1,  1,  -1, 0,  1'b1};  // shortest activity
        vecs[2] = '{1'b0, 12'h123, 3,  5,  3,  0,  1'b1};  // quiet interrupted by output_active
        vecs[3] = '{1'b0, 12'hFFF, 0,  0,  -1, 0,  1'b0};  // load never starts
        vecs[4] = '{1'b0, 12'h0A5, 2,  20, -1, 16, 1'b0};  // reset during WAIT_RUN
        vecs[5] = '{1'b0, 12'h3C5, 4,  2,  -1, 0,  1'b1};  // fresh run after reset
        vecs[6] = '{1'b1, 12'h0AB, 2,  6,  -1, 0,  1'b1};  // stop on the last allowed cycle
        vecs[7] = '{1'b1, 12'h555, 2,  7,  -1, 0,  1'b0};  // stop one cycle too late

        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].sel != sel_b) begin
                sel_b = vecs[i].sel;
                do_reset();
            end
            run_seq(vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
